// File: rtl/magic_nor_sequencer.sv
// Program-driven NOR2/INV executor with MAGIC write-once cell semantics.
// Every cell holds LANES bit-parallel rows, so one run can evaluate a whole truth table.
module magic_nor_sequencer #(
  parameter int NUM_IN     = 4,
  parameter int NUM_CELLS  = 32,
  parameter int PROG_DEPTH = 32,
  parameter int LANES      = 16,
  localparam int AW        = $clog2(NUM_CELLS),
  localparam int PW        = $clog2(PROG_DEPTH),
  localparam int IW        = 3 * AW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prog_we,
  input  logic [PW-1:0]           prog_addr,
  input  logic [IW-1:0]           prog_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*LANES-1:0] in_data,
  input  logic [AW-1:0]           out_cell,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_data,
  output logic                    busy,
  output logic                    err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] FIRST_FREE = AW'(NUM_IN);
  localparam logic [PW-1:0] PC_MAX     = PW'(PROG_DEPTH - 1);

  state_t                 state_q, state_d;
  logic [PW-1:0]          pc_q, pc_d;
  logic [LANES-1:0]       cells_q [NUM_CELLS];
  logic [LANES-1:0]       cells_d [NUM_CELLS];
  logic [NUM_CELLS-1:0]   written_q, written_d;
  logic                   err_q, err_d;

  logic [IW-1:0]          prog_mem_q [PROG_DEPTH];

  logic [IW-1:0]          instr;
  logic                   instr_last;
  logic [AW-1:0]          src_a, src_b, dst;
  logic [LANES-1:0]       nor_val;
  logic                   wr_illegal;

  // Program RAM is deliberately unreset; loads are only honoured while idle.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE)) begin
      prog_mem_q[prog_addr] <= prog_data;
    end
  end

  assign instr      = prog_mem_q[pc_q];
  assign instr_last = instr[IW-1];
  assign src_a      = instr[3*AW-1:2*AW];
  assign src_b      = instr[2*AW-1:AW];
  assign dst        = instr[AW-1:0];
  assign nor_val    = ~(cells_q[src_a] | cells_q[src_b]);
  // A MAGIC output must be pre-SET, so inputs and already-evaluated cells cannot be targets.
  assign wr_illegal = (dst < FIRST_FREE) || written_q[dst];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cells_d   = cells_q;
    written_d = written_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < NUM_IN; i++) begin
            cells_d[i] = in_data[i*LANES +: LANES];
          end
          for (int i = NUM_IN; i < NUM_CELLS; i++) begin
            cells_d[i] = '1;
          end
          written_d = '0;
          err_d     = 1'b0;
          pc_d      = '0;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (wr_illegal) begin
          err_d = 1'b1;
        end else begin
          cells_d[dst]   = nor_val;
          written_d[dst] = 1'b1;
        end
        if (instr_last || (pc_q == PC_MAX)) begin
          state_d = S_DONE;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (prog_we && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      written_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
        cells_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      written_q <= written_d;
      err_q     <= err_d;
      cells_q   <= cells_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign out_data  = cells_q[out_cell];

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Bench for magic_nor_sequencer: vector table, hand-built corner sequences and
// random programs checked against a whole-program reference model.
module tb_magic_nor_sequencer;

  localparam int NUM_IN = 4, NUM_CELLS = 32, PROG_DEPTH = 32, LANES = 16;
  localparam int AW = 5, PW = 5, IW = 16;

  logic                    clk, rst;
  logic                    prog_we;
  logic [PW-1:0]           prog_addr;
  logic [IW-1:0]           prog_data;
  logic                    in_valid, in_ready;
  logic [NUM_IN*LANES-1:0] in_data;
  logic [AW-1:0]           out_cell;
  logic                    out_valid, out_ready;
  logic [LANES-1:0]        out_data;
  logic                    busy, err;

  magic_nor_sequencer #(
    .NUM_IN(NUM_IN), .NUM_CELLS(NUM_CELLS), .PROG_DEPTH(PROG_DEPTH), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_cell(out_cell),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [IW-1:0]    tb_prog [PROG_DEPTH];
  logic [LANES-1:0] m_cells [NUM_CELLS];

  typedef struct {
    logic [IW-1:0]    instr;
    logic [63:0]      din;
    logic [AW-1:0]    oc;
    logic [LANES-1:0] exp_data;
    logic             exp_err;
  } vec_t;

  function automatic logic [IW-1:0] mk(input bit l, input int a, input int b, input int d);
    return {l, 5'(a), 5'(b), 5'(d)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Executes the loaded program straight from the rules: pre-SET outputs, write-once cells.
  task automatic model_run(input logic [63:0] din, output int n, output logic e);
    bit done_bm [NUM_CELLS];
    logic [LANES-1:0] v;
    int a, b, d;
    for (int i = 0; i < NUM_CELLS; i++) begin
      m_cells[i] = (i < NUM_IN) ? din[i*LANES +: LANES] : 16'hFFFF;
      done_bm[i] = 0;
    end
    e = 0;
    n = 0;
    for (int pc = 0; pc < PROG_DEPTH; pc++) begin
      a = int'(tb_prog[pc][14:10]);
      b = int'(tb_prog[pc][9:5]);
      d = int'(tb_prog[pc][4:0]);
      v = ~(m_cells[a] | m_cells[b]);
      if (d < NUM_IN || done_bm[d]) e = 1;
      else begin
        m_cells[d] = v;
        done_bm[d] = 1;
      end
      n = pc + 1;
      if (tb_prog[pc][15]) break;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [IW-1:0] instr);
    prog_we = 1'b1;
    prog_addr = PW'(addr);
    prog_data = instr;
    tick();
    prog_we = 1'b0;
    tb_prog[addr] = instr;
  endtask

  task automatic start_run(input logic [63:0] din);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_data = din;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_drain", 32'({busy, out_valid, in_ready}), 32'b001);
  endtask

  task automatic sweep_cells(input string name);
    for (int c = 0; c < NUM_CELLS; c++) begin
      out_cell = AW'(c);
      #1;
      chk(name, {11'(c), 5'd0, out_data}, {11'(c), 5'd0, m_cells[c]});
    end
  endtask

  task automatic exec_check(input string name, input logic [63:0] din);
    int n, edges;
    logic e;
    model_run(din, n, e);
    start_run(din);
    wait_done(edges);
    chk({name, "_latency"}, 32'(edges), 32'(n));
    chk({name, "_err"}, 32'(err), 32'(e));
    sweep_cells({name, "_cell"});
    drain();
  endtask

  task automatic table_run(input vec_t v, input int idx);
    int edges;
    load(0, v.instr);
    start_run(v.din);
    wait_done(edges);
    out_cell = v.oc;
    #1;
    chk($sformatf("tbl%0d_latency", idx), 32'(edges), 32'd1);
    chk($sformatf("tbl%0d_data", idx), 32'(out_data), 32'(v.exp_data));
    chk($sformatf("tbl%0d_err", idx), 32'(err), 32'(v.exp_err));
    drain();
  endtask

  localparam logic [63:0] TT_IN = {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA};

  task automatic load_parity();
    load(0, mk(0, 0, 1, 4));    load(1, mk(0, 0, 4, 5));
    load(2, mk(0, 1, 4, 6));    load(3, mk(0, 5, 6, 7));
    load(4, mk(0, 2, 3, 8));    load(5, mk(0, 2, 8, 9));
    load(6, mk(0, 3, 8, 10));   load(7, mk(0, 9, 10, 11));
    load(8, mk(0, 7, 11, 12));  load(9, mk(0, 7, 12, 13));
    load(10, mk(0, 11, 12, 14)); load(11, mk(0, 13, 14, 15));
    load(12, mk(0, 15, 15, 16)); load(13, mk(0, 16, 16, 17));
    load(14, mk(0, 16, 3, 18));  load(15, mk(1, 18, 17, 19));
  endtask

  vec_t vecs [6];

  initial begin
    int edges;
    logic [LANES-1:0] held;

    vecs[0] = '{mk(1, 0, 1, 4),   {32'h0, 16'hCCCC, 16'hAAAA}, 5'd4,  16'h1111, 1'b0};
    vecs[1] = '{mk(1, 0, 0, 5),   {48'h0, 16'h00FF},           5'd5,  16'hFF00, 1'b0};
    vecs[2] = '{mk(1, 0, 0, 5),   {48'h0, 16'h00FF},           5'd6,  16'hFFFF, 1'b0};
    vecs[3] = '{mk(1, 2, 3, 0),   {16'h0, 16'h5555, 16'h0, 16'h1234}, 5'd0, 16'h1234, 1'b1};
    vecs[4] = '{mk(1, 1, 1, 31),  {32'h0, 16'h0F0F, 16'h0},    5'd31, 16'hF0F0, 1'b0};
    vecs[5] = '{mk(1, 0, 1, 4),   64'h0,                       5'd4,  16'hFFFF, 1'b0};

    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    in_valid = 1'b0; in_data = '0; out_cell = '0; out_ready = 1'b0;
    for (int i = 0; i < PROG_DEPTH; i++) tb_prog[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    for (int c = 0; c < NUM_CELLS; c++) m_cells[c] = '0;
    sweep_cells("reset_cell");

    for (int i = 0; i < 6; i++) table_run(vecs[i], i);

    // Input cell as destination, then a legal gate afterwards.
    load(0, mk(0, 0, 1, 1));
    load(1, mk(1, 2, 3, 4));
    start_run({32'h0, 16'hCCCC, 16'hAAAA});
    wait_done(edges);
    out_cell = 5'd1; #1;
    chk("illegal_input_latency", 32'(edges), 32'd2);
    chk("illegal_input_data", 32'(out_data), 32'hCCCC);
    chk("illegal_input_err", 32'(err), 32'd1);
    drain();

    // Second write to the same cell is refused.
    load(0, mk(0, 0, 1, 7));
    load(1, mk(1, 2, 3, 7));
    start_run(TT_IN);
    wait_done(edges);
    out_cell = 5'd7; #1;
    chk("rewrite_data", 32'(out_data), 32'h1111);
    chk("rewrite_err", 32'(err), 32'd1);
    drain();

    // 4-input parity truth table, then backpressure.
    load_parity();
    start_run(TT_IN);
    wait_done(edges);
    out_cell = 5'd19; #1;
    chk("tt_latency", 32'(edges), 32'd16);
    chk("tt_data", 32'(out_data), 32'h6996);
    chk("tt_err", 32'(err), 32'd0);
    out_cell = 5'd15; #1;
    chk("tt_xnor4", 32'(out_data), 32'h9669);
    out_cell = 5'd19;
    in_data = 64'h0123_4567_89AB_CDEF;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h6996);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain();

    // Program write during EXEC: dropped, flags err.
    start_run(TT_IN);
    edges = 0;
    while (!out_valid && edges < 200) begin
      if (edges == 4) begin
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = mk(1, 0, 0, 20);
      end else prog_we = 1'b0;
      tick();
      edges++;
    end
    prog_we = 1'b0;
    chk("we_exec_latency", 32'(edges), 32'd16);
    chk("we_exec_err", 32'(err), 32'd1);
    drain();
    exec_check("ram_unchanged", TT_IN);

    // No last bit anywhere: all entries execute.
    for (int i = 0; i < PROG_DEPTH; i++) load(i, mk(0, i % 4, (i + 1) % 4, 4 + (i % 28)));
    exec_check("full_prog", {$urandom, $urandom});

    // Program write in the accept cycle is seen by instruction 0.
    prog_we = 1'b1; prog_addr = 5'd0; prog_data = mk(1, 0, 1, 4);
    in_data = {32'h0, 16'hCCCC, 16'hAAAA};
    in_valid = 1'b1;
    tick();
    prog_we = 1'b0; in_valid = 1'b0;
    tb_prog[0] = mk(1, 0, 1, 4);
    wait_done(edges);
    out_cell = 5'd4; #1;
    chk("accept_write_latency", 32'(edges), 32'd1);
    chk("accept_write_data", 32'(out_data), 32'h1111);
    drain();

    // Asynchronous reset in the middle of a run.
    load_parity();
    start_run(TT_IN);
    prog_we = 1'b1; prog_addr = 5'd2; prog_data = '0;
    tick();
    prog_we = 1'b0;
    tick(); tick();
    chk("pre_reset_err", 32'(err), 32'd1);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    out_cell = 5'd4; #1;
    chk("rst_cell4", 32'(out_data), 32'd0);
    tick();
    rst = 1'b0;
    load(0, mk(1, 0, 1, 4));
    start_run({32'h0, 16'hCCCC, 16'hAAAA});
    wait_done(edges);
    out_cell = 5'd4; #1;
    chk("post_rst_latency", 32'(edges), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h1111);
    drain();

    // Random programs against the reference model.
    for (int it = 0; it < 20; it++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int pc = 0; pc < len; pc++) begin
        int d;
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : 4 + pc;
        load(pc, mk(pc == len - 1, $urandom_range(0, 31), $urandom_range(0, 31), d));
      end
      exec_check($sformatf("rnd%0d", it), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/magic_nor_sequencer.md
Name: magic_nor_sequencer

Overview:
- Parametrised, clocked executor for ABC-mapped NOR/INV netlists under MAGIC in-memory semantics.
- A program RAM holds one NOR2 per entry; INV is NOR2 with both sources equal.
- Each run loads primary-input vectors into a cell array and executes one gate per cycle across LANES bit-parallel rows.
- One lane per input minterm lets a whole truth table be evaluated in a single run. This block replaces per-function hard netlists.

Parameters:
- NUM_IN, 4, primary inputs; these occupy cells 0..NUM_IN-1.
- NUM_CELLS, 32, cell count; must be a power of 2 and greater than NUM_IN.
- PROG_DEPTH, 32, program RAM entries; must be a power of 2.
- LANES, 16, bit-parallel rows per cell.
- AW, clog2(NUM_CELLS), derived, cell index width.
- PW, clog2(PROG_DEPTH), derived, program address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- prog_we  in  1  program RAM write strobe.
- prog_addr  in  PW  program RAM write address.
- prog_data  in  3*AW+1  instruction {last, src_a, src_b, dst}; last is the MSB.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept an input vector.
- in_data  in  NUM_IN*LANES  cell i gets bits [i*LANES +: LANES].
- out_cell  in  AW  index of the cell to present on out_data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  LANES  result cell contents.
- busy  out  1  state is not IDLE.
- err  out  1  sticky error for the current run.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, pc=0, in_ready=1, out_valid=0, busy=0, err=0, all cells=0, written-bitmap=0. Program RAM is not reset; it must be loaded before use.
- State IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready:
    - cells 0..NUM_IN-1 <= in_data slices;
    - cells NUM_IN..NUM_CELLS-1 <= all-ones (MAGIC output pre-SET);
    - written-bitmap cleared; err cleared; pc=0; go to EXEC.
- State EXEC:
  - Each cycle reads entry pc and computes v = ~(cell[src_a] | cell[src_b]) bitwise over LANES.
  - If dst < NUM_IN, or dst is already marked written this run: write is suppressed and err <= 1 (MAGIC cannot re-evaluate an unreset cell).
  - Otherwise cell[dst] <= v and bitmap[dst] <= 1.
  - Sources read pre-edge values. No same-cycle bypass is needed because a write takes effect at the edge.
  - If last=1 or pc==PROG_DEPTH-1: go to DONE. Otherwise pc <= pc+1.
- State DONE:
  - out_valid=1; out_data = cell[out_cell] (combinational; out_cell must be held stable).
  - Leave on out_ready: go to IDLE, out_valid <= 0.
  - Results hold indefinitely under backpressure. in_ready=0 in EXEC and DONE.
- Latency: for an N-instruction program (last set on entry N-1), out_valid rises N edges after the accepting edge.
- Program writes:
  - prog_we is honoured only in IDLE.
  - In EXEC or DONE the write is dropped and err <= 1.
  - A write in the same cycle as an accept is honoured; instruction 0 is read the following cycle.
- err stays readable through DONE and clears on the next accept or on reset.
- Reset mid-run: asynchronous return to the reset values; any partial results are discarded.

Test Plan:
1. Load entry 0 = {1, a=0, b=1, dst=4}; in x0=0xAAAA, x1=0xCCCC; out_cell=4 -> out_valid 1 edge after accept, out_data=0x1111, err=0.
2. Load INV entry 0 = {1, 0, 0, 5}; x0=0x00FF; out_cell=5 -> out_data=0xFF00. Then set out_cell=6 (unwritten) -> out_data=0xFFFF.
3. Illegal writes:
   - Entry 0 = {0, 0, 1, 1} (dst is an input cell), then entry 1 = {1, 2, 3, 4}; x1=0xCCCC; out_cell=1 -> err=1, out_data=0xCCCC unchanged.
   - Separately, two entries both writing dst=7 -> err=1, cell 7 holds the first result.
4. Full 4-input truth-table program (16 NOR/INV gates, last on entry 15):
   - Inputs x0=0xAAAA, x1=0xCCCC, x2=0xF0F0, x3=0xFF00.
   - out_valid exactly 16 edges after accept; out_data matches the golden truth-table word.
   - Hold out_ready=0 for 5 cycles -> out_valid, out_data stable; in_ready=0; a second in_valid is not accepted.
5. Program with no last bit set -> runs all 32 entries; out_valid 32 edges after accept. prog_we pulsed during EXEC -> RAM unchanged, err=1.
6. Assert rst for 1 cycle mid-EXEC (pc=3) -> busy=0, out_valid=0, err=0, in_ready=1 immediately. A subsequent run of scenario 1 yields 0x1111.
